pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register that replaces the fixed per-field control-bus pipeline registers between the fetch, decode, execute, memory and writeback stages. It carries an opaque WIDTH-bit payload, such as a packed control bus, with valid/ready flow control. It adds stall and flush support and a saturating stall-cycle counter. An optional skid entry registers the upstream ready path for timing.

---
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
    parameter int               WIDTH          = 128,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b1,
    parameter int               CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             cnt_clr
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer_in;
    logic             xfer_out;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // Ready comes straight from a flop: no path from out_ready to in_ready.
    assign in_ready = !skid_valid_q;
`else
    assign in_ready = !flush && (!valid_q || out_ready);
`endif

    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = valid_q && out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign stall_cnt = cnt_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            if (CLEAR_ON_FLUSH) begin
                data_d = RESET_VAL;
            end
        end else if (skid_valid_q) begin
            if (xfer_out) begin
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (xfer_in) begin
            if (!valid_q || xfer_out) begin
                data_d  = in_data;
                valid_d = 1'b1;
            end else begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end
        end else if (xfer_out) begin
            valid_d = 1'b0;
        end
`else
        if (flush) begin
            valid_d = 1'b0;
            if (CLEAR_ON_FLUSH) begin
                data_d = RESET_VAL;
            end
        end else if (xfer_in) begin
            data_d  = in_data;
            valid_d = 1'b1;
        end else if (xfer_out) begin
            valid_d = 1'b0;
        end
`endif
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (valid_q && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= RESET_VAL;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_pipe_stage_reg;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hE1;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, in_valid, out_ready, cnt_clr;
    logic [7:0] in_data;

    logic        rdy, ov, rdy2, ov2, rdy3, ov3;
    logic [7:0]  od, od2, od3;
    logic [15:0] sc, sc3;
    logic [1:0]  sc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy), .in_data(in_data), .out_valid(ov), .out_ready(out_ready),
        .out_data(od), .stall_cnt(sc), .cnt_clr(cnt_clr));

    pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV), .CLEAR_ON_FLUSH(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy2), .in_data(in_data), .out_valid(ov2), .out_ready(out_ready),
        .out_data(od2), .stall_cnt(sc2), .cnt_clr(cnt_clr));

    pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV), .CLEAR_ON_FLUSH(1'b0), .CNT_W(16)) u_hold (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy3), .in_data(in_data), .out_valid(ov3), .out_ready(out_ready),
        .out_data(od3), .stall_cnt(sc3), .cnt_clr(cnt_clr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: ordered list of payloads held by the stage.
    logic [7:0] q[$];
    logic [7:0] held_clr, held_hold;
    int         cnt, cnt2;

    function automatic logic mdl_ready();
        if (SKID) return q.size() < 2;
        return !flush && (q.size() == 0 || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            held_clr  = RV;
            held_hold = RV;
            cnt       = 0;
            cnt2      = 0;
        end else begin
            logic acc, pop;
            acc = in_valid && mdl_ready();
            pop = (q.size() > 0) && out_ready;
            if (cnt_clr) begin
                cnt  = 0;
                cnt2 = 0;
            end else if (q.size() > 0 && !out_ready) begin
                if (cnt < 65535) cnt++;
                if (cnt2 < 3) cnt2++;
            end
            if (flush) begin
                if (q.size() > 0) held_hold = q[0];
                held_clr = RV;
                q.delete();
            end else begin
                if (pop) begin
                    held_clr  = q[0];
                    held_hold = q[0];
                    void'(q.pop_front());
                end
                if (acc) q.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        logic       ev;
        logic [7:0] ed, eh;
        ev = q.size() > 0;
        ed = ev ? q[0] : held_clr;
        eh = ev ? q[0] : held_hold;
        chk("cmp_out_valid", 32'(ov), 32'(ev));
        chk("cmp_out_data", 32'(od), 32'(ed));
        chk("cmp_in_ready", 32'(rdy), 32'(mdl_ready()));
        chk("cmp_stall_cnt", 32'(sc), 32'(cnt));
        chk("cmp_sat_cnt", 32'(sc2), 32'(cnt2));
        chk("cmp_hold_valid", 32'(ov3), 32'(ev));
        chk("cmp_hold_data", 32'(od3), 32'(eh));
    end

    task automatic step(input logic v, input logic [7:0] d, input logic r,
                        input logic f, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        cnt_clr   = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(ov), 32'h0);
        chk("rst_out_data", 32'(od), 32'hE1);
        chk("rst_in_ready", 32'(rdy), 32'h1);
        chk("rst_stall_cnt", 32'(sc), 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("first_valid", 32'(ov), 32'h1);
        chk("first_data", 32'(od), 32'hA5);
        step(0, 8'h00, 1, 0, 0);

        for (int i = 1; i <= 8; i++) begin
            step(1, 8'(i), 1, 0, 0);
            chk("stream_data", 32'(od), 32'(i));
            chk("stream_valid", 32'(ov), 32'h1);
        end
        chk("stream_cnt", 32'(sc), 32'h0);
        step(0, 8'h00, 1, 0, 1);

        step(1, 8'h33, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h44, 0, 0, 0);
            chk("stall_in_ready", 32'(rdy), 32'h0);
        end
        chk("stall_data", 32'(od), 32'h33);
        chk("stall_cnt5", 32'(sc), 32'h5);
        step(1, 8'h44, 0, 0, 0);
        chk("stall_cnt6", 32'(sc), 32'h6);
        chk("sat_cnt", 32'(sc2), 32'h3);
        step(1, 8'h44, 0, 0, 1);
        chk("clr_cnt", 32'(sc), 32'h0);
        chk("clr_sat", 32'(sc2), 32'h0);
        step(1, 8'h44, 0, 0, 0);
        chk("clr_then_inc", 32'(sc), 32'h1);
        step(!SKID, 8'h44, 1, 0, 0);
        chk("release_data", 32'(od), 32'h44);
        chk("release_valid", 32'(ov), 32'h1);
        step(0, 8'h00, 1, 0, 1);

        step(1, 8'h55, 0, 0, 0);
        step(1, 8'h66, 0, 0, 0);
        step(1, 8'h77, 0, 1, 0);
        chk("flush_valid", 32'(ov), 32'h0);
        chk("flush_clr_data", 32'(od), 32'hE1);
        chk("flush_hold_data", 32'(od3), 32'h55);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        chk("flush_no_77", 32'(ov), 32'h0);

        step(1, 8'h99, 0, 0, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(ov), 32'h0);
        chk("midrst_data", 32'(od), 32'hE1);
        chk("midrst_cnt", 32'(sc), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 99) == 0);
        end
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        chk("drain_empty", 32'(ov), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
